// File: rtl/pcie_sram_port_arbiter_if.sv
// Requester-side bundle of the PCIe packet SRAM port arbiter: the write
// path and read path request/grant handshakes plus the read return channel.
interface pcie_sram_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 256
);
   logic                  wr_req;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W/8-1:0]   wr_be;
   logic                  wr_gnt;
   logic                  rd_req;
   logic [ADDR_W-1:0]     rd_addr;
   logic                  rd_gnt;
   logic                  rd_rvalid;
   logic [DATA_W-1:0]     rd_rdata;

   // AXI<->SRAM bridges side
   modport master (
      output wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
      input  wr_gnt, rd_gnt, rd_rvalid, rd_rdata
   );

   // Arbiter side
   modport slave (
      input  wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
      output wr_gnt, rd_gnt, rd_rvalid, rd_rdata
   );
endinterface

// File: rtl/pcie_sram_port_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// PCIe write and read paths. Per-cycle arbitration with a sticky owner that
// yields after MAX_HOLD consecutive grants while the other side is waiting.
// Read data returns in order with a fixed 2-cycle latency from acceptance.
module pcie_sram_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 256,
   parameter int MAX_HOLD = 16,
   parameter bit WR_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   pcie_sram_port_arbiter_if.slave bus,
   output logic                sram_cs,
   output logic                sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   output logic [DATA_W/8-1:0] sram_wbe,
   input  logic [DATA_W-1:0]   sram_rdata
);
   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {OWN_NONE, OWN_WR, OWN_RD} owner_t;

   owner_t            owner;
   logic [HOLD_W-1:0] hold_cnt;
   logic              wr_gnt_c;
   logic              rd_gnt_c;
   logic              hold_ok;

   // The incumbent may keep the port only while below its hold budget.
   assign hold_ok = (hold_cnt < HOLD_LIM);

   // Grant decision for this cycle; grants are suppressed while in reset.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case leaves it unassigned and no latch is inferred.
      wr_gnt_c = 1'b0;
      rd_gnt_c = 1'b0;
      if (rst_n) begin
         case (owner)
            OWN_WR: begin
               if (bus.wr_req && (!bus.rd_req || hold_ok)) wr_gnt_c = 1'b1;
               else if (bus.rd_req)                         rd_gnt_c = 1'b1;
            end
            OWN_RD: begin
               if (bus.rd_req && (!bus.wr_req || hold_ok)) rd_gnt_c = 1'b1;
               else if (bus.wr_req)                         wr_gnt_c = 1'b1;
            end
            default: begin
               if (bus.wr_req && bus.rd_req) begin
                  wr_gnt_c = WR_FIRST;
                  rd_gnt_c = !WR_FIRST;
               end else begin
                  wr_gnt_c = bus.wr_req;
                  rd_gnt_c = bus.rd_req;
               end
            end
         endcase
      end
   end

   assign bus.wr_gnt   = wr_gnt_c;
   assign bus.rd_gnt   = rd_gnt_c;
   assign bus.rd_rdata = sram_rdata;

   // Owner FSM, SRAM command register and read-return pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= OWN_NONE;
         hold_cnt   <= '0;
         sram_cs    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_wbe   <= '0;
         bus.rd_rvalid <= 1'b0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         if (wr_gnt_c) begin
            if (owner == OWN_WR) begin
               if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
            end else begin
               owner    <= OWN_WR;
               hold_cnt <= '0;
            end
         end else if (rd_gnt_c) begin
            if (owner == OWN_RD) begin
               if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
            end else begin
               owner    <= OWN_RD;
               hold_cnt <= '0;
            end
         end else begin
            owner    <= OWN_NONE;
            hold_cnt <= '0;
         end

         // Accepted request becomes the SRAM command one cycle later;
         // write data/enables are left untouched by reads and idle cycles.
         sram_cs <= wr_gnt_c | rd_gnt_c;
         if (wr_gnt_c) begin
            sram_we    <= 1'b1;
            sram_addr  <= bus.wr_addr;
            sram_wdata <= bus.wr_data;
            sram_wbe   <= bus.wr_be;
         end else if (rd_gnt_c) begin
            sram_we    <= 1'b0;
            sram_addr  <= bus.rd_addr;
         end

         // A read command on the SRAM this cycle has data next cycle.
         bus.rd_rvalid <= sram_cs & ~sram_we;
      end
   end
endmodule

// File: tb/tb_pcie_sram_port_arbiter.sv
// Self-checking bench for pcie_sram_port_arbiter: directed scenarios plus a
// randomized phase, all compared each cycle against a behavioural model
// (streak-based arbitration, shadow memory, read-return pipeline).
module tb_pcie_sram_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 256;
   localparam int BW = DW / 8;
   localparam int MH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pcie_sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus   ();
   pcie_sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   logic          sram_cs, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata, sram_rdata;
   logic [BW-1:0] sram_wbe;

   logic          b_cs, b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_rdata;
   logic [BW-1:0] b_wbe;
   assign b_rdata = '0;

   pcie_sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH), .WR_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_wbe(sram_wbe), .sram_rdata(sram_rdata)
   );

   pcie_sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH), .WR_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b),
      .sram_cs(b_cs), .sram_we(b_we), .sram_addr(b_addr),
      .sram_wdata(b_wdata), .sram_wbe(b_wbe), .sram_rdata(b_rdata)
   );

   // Packet SRAM model: 1-cycle read latency, byte-enabled writes.
   logic [DW-1:0] sram_mem [1024];
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) begin
            for (int b = 0; b < BW; b++)
               if (sram_wbe[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state (0 = nobody, 1 = write, 2 = read).
   int            own_a, streak_a, own_b, streak_b;
   logic          exp_cs, exp_we;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;
   logic [BW-1:0] exp_wbe;
   logic          rv1, rv2;
   logic [DW-1:0] rd1, rd2;
   logic [DW-1:0] mdl_mem [1024];
   logic          wr_acc, rd_acc, b_wr_acc, b_rd_acc;
   logic          seen_rv;
   logic [DW-1:0] seen_rdata;

   // Who gets the port: the last winner keeps it while it still asks and
   // either the other side is quiet or it has won fewer than MH in a row.
   function automatic int model_grant(input bit wr_first, input int last, input int streak,
                                      input bit wq, input bit rq);
      bit mine, theirs;
      if (!wq && !rq) return 0;
      if (last == 0) begin
         if (wq && rq) return wr_first ? 1 : 2;
         return wq ? 1 : 2;
      end
      mine   = (last == 1) ? wq : rq;
      theirs = (last == 1) ? rq : wq;
      if (mine && (!theirs || streak < MH)) return last;
      return 3 - last;
   endfunction

   task automatic step();
      int g, gb;
      @(negedge clk);
      if (!rst_n) begin
         own_a = 0; streak_a = 0; own_b = 0; streak_b = 0;
         exp_cs = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wbe = '0;
         rv1 = 1'b0; rv2 = 1'b0;
      end
      g  = rst_n ? model_grant(1'b1, own_a, streak_a, bus.wr_req, bus.rd_req) : 0;
      gb = rst_n ? model_grant(1'b0, own_b, streak_b, bus_b.wr_req, bus_b.rd_req) : 0;
      check("wr_gnt", bus.wr_gnt, g == 1);
      check("rd_gnt", bus.rd_gnt, g == 2);
      check("b_wr_gnt", bus_b.wr_gnt, gb == 1);
      check("b_rd_gnt", bus_b.rd_gnt, gb == 2);
      check("sram_cs", sram_cs, exp_cs);
      check("sram_we", sram_we, exp_we);
      check("sram_addr", sram_addr, exp_addr);
      check("sram_wdata", sram_wdata, exp_wdata);
      check("sram_wbe", sram_wbe, exp_wbe);
      check("rd_rvalid", bus.rd_rvalid, rv2);
      if (rv2) check("rd_rdata", bus.rd_rdata, rd2);
      seen_rv    = bus.rd_rvalid;
      seen_rdata = bus.rd_rdata;
      wr_acc = (g == 1);   rd_acc = (g == 2);
      b_wr_acc = (gb == 1); b_rd_acc = (gb == 2);
      if (rst_n) begin
         rv2 = rv1; rd2 = rd1; rv1 = rd_acc;
         exp_cs = (g != 0);
         if (g == 1) begin
            exp_we = 1'b1; exp_addr = bus.wr_addr; exp_wdata = bus.wr_data; exp_wbe = bus.wr_be;
            for (int b = 0; b < BW; b++)
               if (bus.wr_be[b]) mdl_mem[bus.wr_addr][b*8 +: 8] = bus.wr_data[b*8 +: 8];
         end else if (g == 2) begin
            exp_we = 1'b0; exp_addr = bus.rd_addr; rd1 = mdl_mem[bus.rd_addr];
         end
         streak_a = (g == 0) ? 0 : ((g == own_a) ? streak_a + 1 : 1);
         own_a    = g;
         streak_b = (gb == 0) ? 0 : ((gb == own_b) ? streak_b + 1 : 1);
         own_b    = gb;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 7) == 0) ? AW'(10'h3FF) : AW'($urandom_range(0, 15));
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   initial begin
      int ones, rises;
      logic prev_rv;
      logic [7:0] bv;
      logic [DW-1:0] last_data;

      for (int i = 0; i < 1024; i++) begin
         sram_mem[i] = '0;
         mdl_mem[i]  = '0;
      end
      rst_n = 1'b0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
      bus.rd_req = 1'b0; bus.rd_addr = '0;
      bus_b.wr_req = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_be = '0;
      bus_b.rd_req = 1'b0; bus_b.rd_addr = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Single write, then read it back.
      bus.wr_req = 1'b1; bus.wr_addr = 10'h005; bus.wr_data = {BW{8'hA5}}; bus.wr_be = '1;
      step();
      check("t1_wr_acc", wr_acc, 1'b1);
      bus.wr_req = 1'b0;
      check("t1_cs", sram_cs, 1'b1);
      check("t1_we", sram_we, 1'b1);
      check("t1_addr", sram_addr, 10'h005);
      bus.rd_req = 1'b1; bus.rd_addr = 10'h005;
      step();
      check("t2_rd_acc", rd_acc, 1'b1);
      bus.rd_req = 1'b0;
      check("t2_cs", sram_cs, 1'b1);
      check("t2_we", sram_we, 1'b0);
      step();
      check("t2_rvalid", bus.rd_rvalid, 1'b1);
      check("t2_rdata", bus.rd_rdata, {BW{8'hA5}});
      step();

      // Simultaneous requests from idle: tie-break on both instances.
      step();
      bus.wr_req = 1'b1; bus.wr_addr = rnd_addr(); bus.wr_data = rnd_data(); bus.wr_be = '1;
      bus.rd_req = 1'b1; bus.rd_addr = rnd_addr();
      bus_b.wr_req = 1'b1; bus_b.rd_req = 1'b1;
      step();
      check("t3_wr_first", {wr_acc, rd_acc}, 2'b10);
      check("t3_rd_first", {b_wr_acc, b_rd_acc}, 2'b01);
      bus.wr_req = 1'b0; bus_b.wr_req = 1'b0; bus_b.rd_req = 1'b0;
      step();
      check("t3_rd_next", rd_acc, 1'b1);
      bus.rd_req = 1'b0;
      step();

      // Both sides saturating the port: fairness after MH grants.
      bus.wr_req = 1'b1; bus.rd_req = 1'b1;
      for (int i = 0; i < 24; i++) begin
         step();
         check("t4_pattern", {wr_acc, rd_acc}, ((i % 8) < 4) ? 2'b10 : 2'b01);
         if (wr_acc) begin bus.wr_addr = rnd_addr(); bus.wr_data = rnd_data(); end
         if (rd_acc) bus.rd_addr = rnd_addr();
      end
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      repeat (3) step();

      // Fill the top of memory, then stream back-to-back reads.
      for (int i = 0; i < 8; i++) begin
         bv = 8'hC0 + 8'(i);
         bus.wr_req = 1'b1; bus.wr_addr = AW'(10'h3F8 + i); bus.wr_data = {BW{bv}}; bus.wr_be = '1;
         step();
         check("t5_wr_acc", wr_acc, 1'b1);
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b1; bus.rd_addr = 10'h3F8;
      ones = 0; rises = 0; prev_rv = 1'b0; last_data = '0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (rd_acc) begin
            if (bus.rd_addr == 10'h3FF) bus.rd_req = 1'b0;
            else bus.rd_addr = bus.rd_addr + 1'b1;
         end
         if (seen_rv) begin
            ones++;
            last_data = seen_rdata;
         end
         if (seen_rv && !prev_rv) rises++;
         prev_rv = seen_rv;
      end
      bus.rd_req = 1'b0;
      check("t5_rvalid_count", 32'(ones), 32'd8);
      check("t5_rvalid_runs", 32'(rises), 32'd1);
      check("t5_last_data", last_data, {BW{8'hC7}});

      // Reset while a read is in flight.
      bus.rd_req = 1'b1; bus.rd_addr = 10'h010;
      step();
      check("t6_rd_acc", rd_acc, 1'b1);
      bus.rd_req = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_cs", sram_cs, 1'b0);
      check("t6_we", sram_we, 1'b0);
      check("t6_addr", sram_addr, '0);
      ones = 0;
      repeat (3) begin
         step();
         if (seen_rv) ones++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         step();
         if (seen_rv) ones++;
      end
      check("t6_no_rvalid", 32'(ones), 32'd0);
      bus.wr_req = 1'b1; bus.wr_addr = rnd_addr(); bus.wr_data = rnd_data(); bus.wr_be = '1;
      bus.rd_req = 1'b1; bus.rd_addr = rnd_addr();
      step();
      check("t6_owner_none", {wr_acc, rd_acc}, 2'b10);
      bus.wr_req = 1'b0;
      step();
      check("t6_rd_after", rd_acc, 1'b1);
      bus.rd_req = 1'b0;
      step();

      // Randomized traffic with partial byte enables and address collisions.
      for (int i = 0; i < 3000; i++) begin
         if (wr_acc || !bus.wr_req) begin
            bus.wr_req  = ($urandom_range(0, 2) != 0);
            bus.wr_addr = rnd_addr();
            bus.wr_data = rnd_data();
            bus.wr_be   = ($urandom_range(0, 3) == 0) ? '1 : BW'({$urandom, $urandom});
         end
         if (rd_acc || !bus.rd_req) begin
            bus.rd_req  = ($urandom_range(0, 2) != 0);
            bus.rd_addr = rnd_addr();
         end
         step();
      end
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
